// File: rtl/sq_head_align_if.sv
// Stream bundle for sq_head_align: physical-order vectors in, age-order vectors out.
// out_run is carried only when SQ_ALIGN_RUN_EN is defined.
`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

interface sq_head_align_if #(
   parameter int N = `SQ_SIZE
);
   logic                 in_valid;
   logic                 in_ready;
   logic [N-1:0]         in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [N-1:0]         out_data;
`ifdef SQ_ALIGN_RUN_EN
   logic [$clog2(N):0]   out_run;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, out_run);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, out_run);
`else
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/sq_head_align.sv
// Two-stage right-rotator converting SQ status vectors from slot order to age order; owns the SQ head.
// Optional out_run (leading-ones count from the oldest entry) enabled by defining SQ_ALIGN_RUN_EN.
`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

module sq_head_align #(
   parameter int N    = `SQ_SIZE,
   parameter bit CIRC = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 retire_valid,
   input  logic [$clog2(N):0]   retire_cnt,
   input  logic                 flush,
   sq_head_align_if.slave       bus,
   output logic [$clog2(N)-1:0] head
);
   localparam int SW = $clog2(N);
   localparam int LO = SW / 2;
   localparam int HI = SW - LO;

   logic [SW-1:0] head_reg;
   logic          s1_valid_reg;
   logic [N-1:0]  s1_data_reg;
   logic [HI-1:0] s1_hi_reg;
   logic          s2_valid_reg;
   logic [N-1:0]  s2_data_reg;

   logic          s2_ready;
   logic          accept;
   logic [N-1:0]  s1_rot;
   logic [N-1:0]  s2_rot;

   // CIRC=0 discards the low bits instead of wrapping them, so the top fills with zeros.
   function automatic logic [N-1:0] rot_right(input logic [N-1:0] x, input int amt);
      logic [2*N-1:0] w;
      w = CIRC ? {x, x} : {{N{1'b0}}, x};
      return N'(w >> amt);
   endfunction

   assign s2_ready     = !s2_valid_reg || bus.out_ready;
   assign bus.in_ready = (!s1_valid_reg || s2_ready) && !flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // Low shift bits applied on the way into stage 1; high bits travel with the beat.
   assign s1_rot = rot_right(bus.in_data, int'(head_reg[LO-1:0]));
   assign s2_rot = rot_right(s1_data_reg, int'(s1_hi_reg) << LO);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_reg <= '0;
      end else if (retire_valid) begin
         head_reg <= SW'({1'b0, head_reg} + retire_cnt);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         s1_hi_reg    <= '0;
         s2_valid_reg <= 1'b0;
         s2_data_reg  <= '0;
      end else begin
         if (flush) begin
            s1_valid_reg <= 1'b0;
         end else if (!s1_valid_reg || s2_ready) begin
            s1_valid_reg <= accept;
         end
         if (accept) begin
            s1_data_reg <= s1_rot;
            s1_hi_reg   <= head_reg[SW-1:LO];
         end
         if (flush) begin
            s2_valid_reg <= 1'b0;
         end else if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
         end
         if (s2_ready && s1_valid_reg && !flush) begin
            s2_data_reg <= s2_rot;
         end
      end
   end

`ifdef SQ_ALIGN_RUN_EN
   logic [SW:0] s2_run;
   logic [SW:0] out_run_reg;

   function automatic logic [SW:0] lead_ones(input logic [N-1:0] x);
      logic [SW:0] cnt;
      logic        stop;
      cnt  = '0;
      stop = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!stop) begin
            if (x[i]) cnt = cnt + (SW+1)'(1);
            else      stop = 1'b1;
         end
      end
      return cnt;
   endfunction

   assign s2_run = lead_ones(s2_rot);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_run_reg <= '0;
      end else if (s2_ready && s1_valid_reg && !flush) begin
         out_run_reg <= s2_run;
      end
   end

   assign bus.out_run = out_run_reg;
`endif

   assign bus.out_valid = s2_valid_reg;
   assign bus.out_data  = s2_data_reg;
   assign head          = head_reg;

endmodule

// File: tb/tb_sq_head_align.sv
// Directed bench for sq_head_align (N=8): rotation, head update, stall, flush and reset cases.
// Define SQ_ALIGN_RUN_EN to also check out_run.
`timescale 1ns/1ps

module tb_sq_head_align;
   localparam int N    = 8;
   localparam bit CIRC = 1'b1;

   logic       clock;
   logic       reset_n;
   logic       retire_valid;
   logic [3:0] retire_cnt;
   logic       flush;
   logic [2:0] head;

   int n_checks = 0;
   int n_errors = 0;

   sq_head_align_if #(.N(N)) bus ();

   sq_head_align #(.N(N), .CIRC(CIRC)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .retire_valid (retire_valid),
      .retire_cnt   (retire_cnt),
      .flush        (flush),
      .bus          (bus),
      .head         (head)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (retire_valid) begin
         assert (retire_cnt <= N) else $error("illegal retire_cnt %0d", retire_cnt);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] exp, input int run);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
`ifdef SQ_ALIGN_RUN_EN
      chk({tag, "_run"}, 32'(bus.out_run), 32'(run));
`endif
   endtask

   // One beat through an idle pipeline: checks latency, value and hold-after-drain.
   task automatic send1(input string tag, input logic [7:0] d, input logic [7:0] exp, input int run);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
      tick();
      chk_out(tag, exp, run);
      tick();
      chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_hold"}, 32'(bus.out_data), 32'(exp));
   endtask

   task automatic retire(input string tag, input logic rv, input logic [3:0] cnt, input logic [2:0] exp_head);
      retire_valid = rv;
      retire_cnt   = cnt;
      tick();
      retire_valid = 1'b0;
      retire_cnt   = '0;
      chk(tag, 32'(head), 32'(exp_head));
   endtask

   initial begin
      reset_n       = 1'b0;
      retire_valid  = 1'b0;
      retire_cnt    = '0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      #12;
      chk("rst_head", 32'(head), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef SQ_ALIGN_RUN_EN
      chk("rst_out_run", 32'(bus.out_run), 32'd0);
`endif
      tick();
      reset_n = 1'b1;
      tick();

      send1("h0_81", 8'b1000_0001, 8'b1000_0001, 1);

      retire("ret3", 1'b1, 4'd3, 3'd3);
      send1("h3_07", 8'b0000_0111, CIRC ? 8'b1110_0000 : 8'b0000_0000, 0);
      send1("h3_38", 8'b0011_1000, 8'b0000_0111, 3);
      send1("h3_ff", 8'hFF, CIRC ? 8'hFF : 8'h1F, CIRC ? 8 : 5);
      send1("h3_f7", 8'b1111_0111, CIRC ? 8'b1111_1110 : 8'b0001_1110, 0);

      // Accept and retire on the same edge: beat must use the old head (3).
      bus.in_valid = 1'b1;
      bus.in_data  = 8'b0000_0001;
      retire_valid = 1'b1;
      retire_cnt   = 4'd3;
      tick();
      bus.in_valid = 1'b0;
      retire_valid = 1'b0;
      retire_cnt   = '0;
      chk("acc_ret_head", 32'(head), 32'd6);
      tick();
      chk_out("acc_ret", CIRC ? 8'b0010_0000 : 8'b0000_0000, 0);
      tick();

      retire("ret4_wrap", 1'b1, 4'd4, 3'd2);
      retire("ret8_same", 1'b1, 4'd8, 3'd2);
      retire("ret_inval", 1'b0, 4'd5, 3'd2);

      // Stall: out_ready low for 4 cycles, three beats offered, only two fit.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h04;
      #1 chk("stall_rdy0", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_data = 8'h08;
      #1 chk("stall_rdy1", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_data = 8'h10;
      #1 chk("stall_rdy2", 32'(bus.in_ready), 32'd0);
      chk("stall_hold2", 32'(bus.out_data), 32'h01);
      tick();
      #1 chk("stall_rdy3", 32'(bus.in_ready), 32'd0);
      chk("stall_hold3", 32'(bus.out_data), 32'h01);
      tick();
      bus.out_ready = 1'b1;
      #1 chk("stall_rdy4", 32'(bus.in_ready), 32'd1);
      chk_out("stall_a", 8'h01, 1);
      tick();
      bus.in_valid = 1'b0;
      chk_out("stall_b", 8'h02, 0);
      tick();
      chk_out("stall_c", 8'h04, 0);
      tick();
      chk("stall_empty", 32'(bus.out_valid), 32'd0);

      // Flush with two beats in flight, plus a retire that must still apply.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h0C;
      tick();
      bus.in_data = 8'h30;
      tick();
      bus.in_data  = 8'hC0;
      flush        = 1'b1;
      retire_valid = 1'b1;
      retire_cnt   = 4'd1;
      #1 chk("flush_in_rdy", 32'(bus.in_ready), 32'd0);
      tick();
      flush        = 1'b0;
      retire_valid = 1'b0;
      retire_cnt   = '0;
      bus.in_valid = 1'b0;
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_head", 32'(head), 32'd3);
      tick();
      chk("flush_valid2", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset with beats in flight.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      tick();
      tick();
      bus.in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_head", 32'(head), 32'd0);
      chk("arst_data", 32'(bus.out_data), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("arst_s1_gone", 32'(bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
